// File: rtl/decimal_entry_accumulator_pkg.sv
// Shared types and helpers for the decimal entry path (digit register and
// BCD-to-binary converter).
package calc_entry_pkg;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;
  // Widest BCD vector the helper accepts; covers NUM_DIGITS up to 12.
  localparam int          BCD_MAX_W = 48;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  function automatic logic [DIGIT_W-1:0] bcd_digit(
    input logic [BCD_MAX_W-1:0] vec,
    input int                   idx
  );
    return vec[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/bcd_to_binary_iter.sv
// Iterative BCD-to-binary converter: one Horner step (acc*10 + digit) per cycle,
// MSD first, from a snapshot taken on the start strobe.
module bcd_to_binary_iter
  import calc_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VALUE_W    = 40
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [4*NUM_DIGITS-1:0]   i_bcd,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [VALUE_W-1:0]        o_value
);

  localparam int IDX_W = $clog2(NUM_DIGITS + 1);

  state_e                    r_state;
  logic [4*NUM_DIGITS-1:0]   r_snap;
  logic [VALUE_W-1:0]        r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_busy;
  logic [VALUE_W-1:0]        r_value;

  logic [DIGIT_W-1:0]        w_digit;
  logic [VALUE_W-1:0]        w_acc_next;
  logic                      w_last;

  // Horner step on the digit selected by idx (MSD first).
  always_comb begin
    w_digit    = bcd_digit(BCD_MAX_W'(r_snap), int'(NUM_DIGITS - 1) - int'(r_idx));
    w_acc_next = (r_acc << 3) + (r_acc << 1) + VALUE_W'(w_digit);
    w_last     = (r_state == CONVERT) && (r_idx == IDX_W'(NUM_DIGITS - 1));
  end

  // Conversion FSM; abort beats start, and start beats finishing so an edit on
  // the last step restarts from the new snapshot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_value <= '0;
    end else if (i_abort) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_value <= '0;
    end else if (i_start) begin
      r_state <= CONVERT;
      r_snap  <= i_bcd;
      r_acc   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
        end
        CONVERT: begin
          if (w_last) begin
            r_value <= w_acc_next;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
          end else begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = w_last;
  assign o_value = r_value;

endmodule

// File: rtl/decimal_entry_accumulator.sv
// Decimal operand entry: packed-BCD digit register with backspace, clear and
// sign, plus a background conversion of the digits to a binary magnitude.
module decimal_entry_accumulator
  import calc_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VALUE_W    = 40
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [3:0]                i_digit,
  input  logic                      i_digit_pulse,
  input  logic                      i_backspace_pulse,
  input  logic                      i_clear_pulse,
  input  logic                      i_sign_pulse,
  output logic [4*NUM_DIGITS-1:0]   o_bcd,
  output logic [2:0]                o_digit_count,
  output logic                      o_sign,
  output logic [VALUE_W-1:0]        o_value,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int         BCD_W     = DIGIT_W * NUM_DIGITS;
  localparam logic [2:0] MAX_COUNT = 3'(NUM_DIGITS);

  logic [BCD_W-1:0] r_bcd;
  logic [2:0]       r_count;
  logic             r_sign;
  logic             r_err;
  logic             r_valid;

  logic [BCD_W-1:0] w_bcd_next;
  logic [2:0]       w_count_next;
  logic             w_sign_next;
  logic             w_err_next;
  logic             w_start;
  logic             w_abort;
  logic             w_done;

  // Strobe priority: clear > backspace > digit > sign; only one acts per cycle.
  always_comb begin
    w_bcd_next   = r_bcd;
    w_count_next = r_count;
    w_sign_next  = r_sign;
    w_err_next   = 1'b0;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    if (i_clear_pulse) begin
      w_bcd_next   = '0;
      w_count_next = 3'd0;
      w_sign_next  = 1'b0;
      w_abort      = 1'b1;
    end else if (i_backspace_pulse) begin
      if (r_count != 3'd0) begin
        w_bcd_next   = r_bcd >> DIGIT_W;
        w_count_next = r_count - 3'd1;
        w_start      = 1'b1;
        if (r_count == 3'd1) begin
          w_sign_next = 1'b0;
        end else begin
          w_sign_next = r_sign;
        end
      end else begin
        w_bcd_next = r_bcd;
      end
    end else if (i_digit_pulse) begin
      if ((i_digit > MAX_DIGIT) || (r_count == MAX_COUNT)) begin
        w_err_next = 1'b1;
      end else if ((r_count == 3'd0) && (i_digit == 4'd0)) begin
        // Leading zero: accepted but leaves the entry empty.
        w_err_next = 1'b0;
      end else begin
        w_bcd_next   = {r_bcd[BCD_W-DIGIT_W-1:0], i_digit};
        w_count_next = r_count + 3'd1;
        w_start      = 1'b1;
      end
    end else if (i_sign_pulse) begin
      if (r_count != 3'd0) begin
        w_sign_next = ~r_sign;
      end else begin
        w_sign_next = r_sign;
      end
    end else begin
      w_err_next = 1'b0;
    end
  end

  // Entry registers and the validity flag that tracks the converter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bcd   <= '0;
      r_count <= 3'd0;
      r_sign  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b1;
    end else begin
      r_bcd   <= w_bcd_next;
      r_count <= w_count_next;
      r_sign  <= w_sign_next;
      r_err   <= w_err_next;
      if (w_abort) begin
        r_valid <= 1'b1;
      end else if (w_start) begin
        r_valid <= 1'b0;
      end else if (w_done) begin
        r_valid <= 1'b1;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  bcd_to_binary_iter #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_conv (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (w_start),
    .i_abort   (w_abort),
    .i_bcd     (w_bcd_next),
    .o_busy    (o_busy),
    .o_done    (w_done),
    .o_value   (o_value)
  );

  assign o_bcd         = r_bcd;
  assign o_digit_count = r_count;
  assign o_sign        = r_sign;
  assign o_err         = r_err;
  assign o_valid       = r_valid;

endmodule

// File: tb/tb_decimal_entry_accumulator.sv
// Directed self-checking bench for decimal_entry_accumulator.
module tb_decimal_entry_accumulator;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit;
  logic        digit_pulse;
  logic        bs_pulse;
  logic        clr_pulse;
  logic        sign_pulse;
  logic [23:0] bcd;
  logic [2:0]  count;
  logic        sign;
  logic [39:0] value;
  logic        valid;
  logic        busy;
  logic        err;

  int checks;
  int errors;

  decimal_entry_accumulator dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_digit           (digit),
    .i_digit_pulse     (digit_pulse),
    .i_backspace_pulse (bs_pulse),
    .i_clear_pulse     (clr_pulse),
    .i_sign_pulse      (sign_pulse),
    .o_bcd             (bcd),
    .o_digit_count     (count),
    .o_sign            (sign),
    .o_value           (value),
    .o_valid           (valid),
    .o_busy            (busy),
    .o_err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of strobes; returns 1ns after the edge that sampled them.
  task automatic strobe(input logic cl, input logic bs, input logic dp,
                        input logic sp, input logic [3:0] d);
    digit = d; clr_pulse = cl; bs_pulse = bs; digit_pulse = dp; sign_pulse = sp;
    @(posedge clk); #1;
    clr_pulse = 1'b0; bs_pulse = 1'b0; digit_pulse = 1'b0; sign_pulse = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, d);
  endtask

  // Wait for busy to drop, bounded; returns number of busy cycles seen.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bcd, count, sign, value, valid, busy, err} !== {24'h0, 3'd0, 1'b0, 40'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: bcd=%h cnt=%0d sign=%b val=%0d valid=%b busy=%b err=%b", bcd, count, sign, value, valid, busy, err);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_entry();
    int n;
    key(4'd1); key(4'd2); key(4'd3);
    checks++;
    if (bcd !== 24'h000123 || count !== 3'd3 || valid !== 1'b0) begin
      errors++;
      $display("FAIL entry_bcd: bcd=%h cnt=%0d valid=%b, required 000123 3 0", bcd, count, valid);
    end
    wait_idle(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL entry_latency: busy cycles=%0d, required 6", n);
    end
    checks++;
    if (value !== 40'd123 || valid !== 1'b1) begin
      errors++;
      $display("FAIL entry_value: value=%0d valid=%b, required 123 1", value, valid);
    end
  endtask

  task automatic test_backspace();
    int n;
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bcd !== 24'h000012 || count !== 3'd2 || valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL backspace: bcd=%h cnt=%0d valid=%b busy=%b, required 000012 2 0 1", bcd, count, valid, busy);
    end
    wait_idle(n);
    checks++;
    if (value !== 40'd12 || valid !== 1'b1 || n !== 6) begin
      errors++;
      $display("FAIL backspace_value: value=%0d valid=%b cycles=%0d, required 12 1 6", value, valid, n);
    end
  endtask

  task automatic test_overflow();
    int n;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5); key(4'd4);
    key(4'd3);
    checks++;
    if (err !== 1'b1 || bcd !== 24'h987654 || count !== 3'd6) begin
      errors++;
      $display("FAIL overflow_err: err=%b bcd=%h cnt=%0d, required 1 987654 6", err, bcd, count);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_err_pulse: err=%b, required 0", err);
    end
    wait_idle(n);
    checks++;
    if (value !== 40'd987654 || valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_value: value=%0d valid=%b, required 987654 1", value, valid);
    end
  endtask

  task automatic test_invalid();
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key(4'hA);
    checks++;
    if (err !== 1'b1 || bcd !== 24'h0 || busy !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL invalid_digit: err=%b bcd=%h busy=%b cnt=%0d, required 1 0 0 0", err, bcd, busy, count);
    end
    key(4'd0);
    checks++;
    if (err !== 1'b0 || count !== 3'd0 || busy !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL leading_zero: err=%b cnt=%0d busy=%b valid=%b, required 0 0 0 1", err, count, busy, valid);
    end
  endtask

  task automatic test_clear_abort();
    int n;
    key(4'd7);
    wait_idle(n);
    checks++;
    if (value !== 40'd7) begin
      errors++;
      $display("FAIL pre_clear_value: value=%0d, required 7", value);
    end
    key(4'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (busy !== 1'b0 || value !== 40'd0 || valid !== 1'b1 || count !== 3'd0 || bcd !== 24'h0) begin
      errors++;
      $display("FAIL clear_abort: busy=%b value=%0d valid=%b cnt=%0d bcd=%h, required 0 0 1 0 0", busy, value, valid, count, bcd);
    end
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
    checks++;
    if (count !== 3'd0 || bcd !== 24'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_digit: cnt=%0d bcd=%h busy=%b, required 0 0 0", count, bcd, busy);
    end
  endtask

  task automatic test_sign();
    int n;
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (sign !== 1'b0) begin
      errors++;
      $display("FAIL sign_empty: sign=%b, required 0", sign);
    end
    key(4'd4); key(4'd2);
    wait_idle(n);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (sign !== 1'b1 || value !== 40'd42 || valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sign_toggle: sign=%b value=%0d valid=%b busy=%b, required 1 42 1 0", sign, value, valid, busy);
    end
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
    checks++;
    if (bcd !== 24'h000004 || count !== 3'd1 || sign !== 1'b1) begin
      errors++;
      $display("FAIL bs_beats_digit: bcd=%h cnt=%0d sign=%b, required 000004 1 1", bcd, count, sign);
    end
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (sign !== 1'b0 || count !== 3'd0 || bcd !== 24'h0) begin
      errors++;
      $display("FAIL sign_clears: sign=%b cnt=%0d bcd=%h, required 0 0 0", sign, count, bcd);
    end
    wait_idle(n);
  endtask

  task automatic test_async_reset();
    key(4'd8); key(4'd1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bcd, count, sign, value, valid, busy, err} !== {24'h0, 3'd0, 1'b0, 40'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: bcd=%h cnt=%0d sign=%b val=%0d valid=%b busy=%b err=%b", bcd, count, sign, value, valid, busy, err);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; digit = 4'd0;
    digit_pulse = 1'b0; bs_pulse = 1'b0; clr_pulse = 1'b0; sign_pulse = 1'b0;
    test_reset();
    test_entry();
    test_backspace();
    test_overflow();
    test_invalid();
    test_clear_abort();
    test_sign();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
